// File: rtl/boton_contador.sv
// ----------------------------------------------------------------------------
// boton_contador
//
// Inward path for the icestick: counts debounced presses of an external
// push-button and shows the count on the 5 leds.
//
//   btn -> 2-FF synchroniser -> debounce FSM (+ 20-bit timer) -> 5-bit count
//
// Optional feature (compile-time macro BOTON_AUTOREPEAT_EN):
//   while the button stays pressed, the count also advances once every
//   REP_CYCLES clocks, using a 23-bit repeat timer. With the macro undefined
//   the repeat logic is absent and each press counts exactly once.
//
// Parameters:
//   DEB_CYCLES  debounce time in clk cycles (2 .. 2^20-1)
//   REP_CYCLES  auto-repeat interval in clk cycles (2 .. 2^23-1)
//
// Ports:
//   clk   in   system clock
//   rstn  in   synchronous active-low reset
//   btn   in   raw push-button, active-high, asynchronous, may bounce
//   leds  out  current press count (registered)
//   tic   out  one-cycle strobe, high together with each new leds value
// ----------------------------------------------------------------------------
module boton_contador #(
  parameter int unsigned DEB_CYCLES = 120000,
  parameter int unsigned REP_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn,
  output logic [4:0] leds,
  output logic       tic
);

  // Debounce FSM encoding
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DEB_PRESS = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] DEB_REL   = 2'd3;

  // Terminal value of the debounce timer
  localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 32'd1);

  // Reject parameter values the timers cannot represent
  if ((DEB_CYCLES < 32'd2) || (DEB_CYCLES > 32'd1048575)) begin : g_bad_deb
    $error("boton_contador: DEB_CYCLES out of range 2..2^20-1");
  end
  if ((REP_CYCLES < 32'd2) || (REP_CYCLES > 32'd8388607)) begin : g_bad_rep
    $error("boton_contador: REP_CYCLES out of range 2..2^23-1");
  end

  logic        s1_r;
  logic        btn_s_r;
  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [19:0] timer_r;
  logic [19:0] timer_s;
  logic [4:0]  count_r;
  logic [4:0]  count_s;
  logic        tic_r;
  logic        tic_s;

`ifdef BOTON_AUTOREPEAT_EN
  // Terminal value of the repeat timer
  localparam logic [22:0] REP_LAST = 23'(REP_CYCLES - 32'd1);

  logic [22:0] rep_r;
  logic [22:0] rep_s;
`endif

  // Two-flop synchroniser bringing the raw button into the clk domain
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_r    <= 1'b0;
      btn_s_r <= 1'b0;
    end else begin
      s1_r    <= btn;
      btn_s_r <= s1_r;
    end
  end

  // Debounce FSM next-state, timer and counter logic
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    count_s = count_r;
    tic_s   = 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
    // Repeat timer is zero everywhere outside PRESSED
    rep_s   = 23'd0;
`endif
    case (state_r)
      IDLE: begin
        if (btn_s_r) begin
          state_s = DEB_PRESS;
          timer_s = 20'd0;
        end else begin
          timer_s = 20'd0;
        end
      end

      DEB_PRESS: begin
        if (!btn_s_r) begin
          // Glitch: abort the press without counting
          state_s = IDLE;
          timer_s = 20'd0;
        end else if (timer_r == DEB_LAST) begin
          state_s = PRESSED;
          timer_s = 20'd0;
          count_s = count_r + 5'd1;  // wraps 31 -> 0
          tic_s   = 1'b1;
        end else begin
          timer_s = timer_r + 20'd1;
        end
      end

      PRESSED: begin
        if (!btn_s_r) begin
          state_s = DEB_REL;
          timer_s = 20'd0;
        end else begin
`ifdef BOTON_AUTOREPEAT_EN
          if (rep_r == REP_LAST) begin
            count_s = count_r + 5'd1;
            tic_s   = 1'b1;
            rep_s   = 23'd0;
          end else begin
            rep_s   = rep_r + 23'd1;
          end
`else
          timer_s = 20'd0;
`endif
        end
      end

      DEB_REL: begin
        if (btn_s_r) begin
          // Release bounce: go back to PRESSED without counting again;
          // the repeat timer (if present) restarts from zero.
          state_s = PRESSED;
          timer_s = 20'd0;
        end else if (timer_r == DEB_LAST) begin
          state_s = IDLE;
          timer_s = 20'd0;
        end else begin
          timer_s = timer_r + 20'd1;
        end
      end

      default: begin
        state_s = IDLE;
        timer_s = 20'd0;
      end
    endcase
  end

  // FSM, timer, counter and strobe registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
      timer_r <= 20'd0;
      count_r <= 5'd0;
      tic_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      count_r <= count_s;
      tic_r   <= tic_s;
    end
  end

`ifdef BOTON_AUTOREPEAT_EN
  // Auto-repeat timer register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rep_r <= 23'd0;
    end else begin
      rep_r <= rep_s;
    end
  end
`endif

  // Outputs come straight from registers
  assign leds = count_r;
  assign tic  = tic_r;

endmodule

// File: tb/tb_boton_contador.sv
// ----------------------------------------------------------------------------
// tb_boton_contador
//
// Scoreboard bench for boton_contador with DEB_CYCLES=4, REP_CYCLES=10.
// The stimulus process pushes the expected leds value of every count it
// expects; a monitor pops one entry per tic pulse and compares. Directed
// leds/tic checks cover latency, reset and idle periods.
// ----------------------------------------------------------------------------
module tb_boton_contador;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn;
  logic [4:0] leds;
  logic       tic;

  int total = 0;
  int bad   = 0;
  int tics  = 0;
  int tics0 = 0;

  logic [4:0] sb[$];
  logic [4:0] exp_cnt;
  logic [4:0] mon_exp;

  always #5 clk = ~clk;

  boton_contador #(
    .DEB_CYCLES(4),
    .REP_CYCLES(10)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .btn (btn),
    .leds(leds),
    .tic (tic)
  );

  // Advance n rising edges, returning 1 time unit after the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Model one expected increment and queue its leds value
  task automatic expect_cnt();
    exp_cnt = exp_cnt + 5'd1;
    sb.push_back(exp_cnt);
  endtask

  // Monitor: every tic pulse must match the next queued count
  always @(negedge clk) begin
    if (tic === 1'b1) begin
      tics++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_tic: unexpected tic with leds=%0d", leds);
      end else begin
        mon_exp = sb.pop_front();
        if (leds !== mon_exp) begin
          bad++;
          $display("FAIL sb_leds: got %0d expected %0d", leds, mon_exp);
        end
      end
    end
  end

  initial begin
    exp_cnt = 5'd0;

    // Reset with button held
    btn  = 1'b1;
    rstn = 1'b0;
    cyc(2);
    chk("rst_leds", int'(leds), 0);
    chk("rst_tic", int'(tic), 0);
    expect_cnt();
    rstn = 1'b1;
    cyc(6);
    chk("rst_lat_notic", int'(tic), 0);
    chk("rst_lat_leds0", int'(leds), 0);
    cyc(1);
    chk("rst_lat_tic", int'(tic), 1);
    chk("rst_lat_leds1", int'(leds), 1);
    cyc(1);
    chk("rst_tic_1cyc", int'(tic), 0);
    btn = 1'b0;
    cyc(10);

    // Clean press held 20 cycles
    expect_cnt();
`ifdef BOTON_AUTOREPEAT_EN
    expect_cnt();
`endif
    btn = 1'b1;
    cyc(6);
    chk("clean_notic", int'(tic), 0);
    chk("clean_leds_pre", int'(leds), 1);
    cyc(1);
    chk("clean_tic", int'(tic), 1);
    chk("clean_leds", int'(leds), 2);
    cyc(1);
    chk("clean_tic_1cyc", int'(tic), 0);
    cyc(12);
    btn = 1'b0;
    cyc(12);
    chk("clean_leds_end", int'(leds), int'(exp_cnt));

    // Press bounce: high 2, low 1, high 2, low
    btn = 1'b1; cyc(2);
    btn = 1'b0; cyc(1);
    btn = 1'b1; cyc(2);
    btn = 1'b0; cyc(10);
    chk("bounce_press", int'(leds), int'(exp_cnt));

    // Release bounce: 1-cycle pulses every 3 cycles
    expect_cnt();
    btn = 1'b1;
    cyc(9);
    for (int i = 0; i < 4; i++) begin
      btn = 1'b0; cyc(2);
      btn = 1'b1; cyc(1);
    end
    btn = 1'b0;
    cyc(12);
    chk("bounce_rel", int'(leds), int'(exp_cnt));

    // Wrap: 32 presses from zero
    rstn = 1'b0;
    cyc(2);
    exp_cnt = 5'd0;
    chk("wrap_rst", int'(leds), 0);
    rstn  = 1'b1;
    tics0 = tics;
    for (int i = 1; i <= 32; i++) begin
      expect_cnt();
      btn = 1'b1; cyc(8);
      btn = 1'b0; cyc(8);
      if (i == 31) chk("wrap_31", int'(leds), 31);
      if (i == 32) chk("wrap_0", int'(leds), 0);
    end
    chk("wrap_tics", tics - tics0, 32);

    // Reset in the middle of DEB_PRESS
    expect_cnt();
    btn = 1'b1; cyc(8);
    btn = 1'b0; cyc(10);
    chk("mid_pre", int'(leds), 1);
    btn = 1'b1;
    cyc(5);
    rstn = 1'b0;
    btn  = 1'b0;
    cyc(1);
    exp_cnt = 5'd0;
    chk("mid_rst_leds", int'(leds), 0);
    chk("mid_rst_tic", int'(tic), 0);
    rstn = 1'b1;
    cyc(12);
    chk("mid_after", int'(leds), 0);

    // Hold 35 cycles after debounce
    expect_cnt();
`ifdef BOTON_AUTOREPEAT_EN
    expect_cnt();
    expect_cnt();
    expect_cnt();
`endif
    btn = 1'b1;
    cyc(7);
    chk("hold_first", int'(leds), 1);
    cyc(35);
    btn = 1'b0;
    cyc(12);
`ifdef BOTON_AUTOREPEAT_EN
    chk("hold_leds", int'(leds), 4);
`else
    chk("hold_leds", int'(leds), 1);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
